duty_level_sequencer: RTL and testbench

Sits between the key debouncer and the PWM generator in the LED/indicator path of the anti-pinch system. Each debounced key-press strobe advances through six brightness levels (0 %, 5 %, 10 %, 25 %, 50 %, 100 %). It outputs the percent duty value that the PWM stage compares against. With the ramp feature compiled in, the duty glides 1 % per tick toward the new level, giving the breathing effect, instead of jumping.

---
 rtl/duty_seq_pkg.sv | 38 +++
 rtl/duty_level_sequencer_ramp_tick.sv | 44 ++++
 rtl/duty_level_sequencer.sv | 101 ++++++++++
 tb/tb_duty_level_sequencer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/duty_seq_pkg.sv
// ---------------------------------------------------------------------------
// duty_seq_pkg : shared widths, level->duty table and FSM states for the
//                duty level sequencer.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package duty_seq_pkg;

  localparam int NUM_LEVELS = 6;
  localparam int DUTY_W     = 7;
  localparam int LEVEL_W    = 3;

  typedef logic [DUTY_W-1:0]  duty_t;
  typedef logic [LEVEL_W-1:0] level_t;

  localparam duty_t LEVEL_DUTY [NUM_LEVELS] = '{7'd0, 7'd5, 7'd10, 7'd25, 7'd50, 7'd100};

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RAMP = 1'b1
  } state_e;

  function automatic level_t next_level(input level_t lvl);
    return (lvl == LEVEL_W'(NUM_LEVELS - 1)) ? '0 : lvl + LEVEL_W'(1);
  endfunction

  function automatic duty_t level_duty(input level_t lvl);
    duty_t d;
    d = '0;
    for (int i = 0; i < NUM_LEVELS; i++) begin
      if (lvl == LEVEL_W'(i)) d = LEVEL_DUTY[i];
    end
    return d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/duty_level_sequencer_ramp_tick.sv
// ---------------------------------------------------------------------------
// ramp_tick : prescaler with synchronous clear; one-cycle tick every
//             RAMP_STEP_CYC enabled cycles.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ramp_tick #(
  parameter int unsigned RAMP_STEP_CYC = 100000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CNT_W = (RAMP_STEP_CYC > 2) ? $clog2(RAMP_STEP_CYC) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(RAMP_STEP_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || !en_i || (cnt_q == TERM)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A clear in the terminal-count cycle swallows that tick.
  assign tick_o = en_i && !clr_i && (cnt_q == TERM);

endmodule

`default_nettype wire

// File: rtl/duty_level_sequencer.sv
// ---------------------------------------------------------------------------
// duty_level_sequencer : key-stepped six-level duty selector for the PWM
//   stage; DUTY_RAMP_EN adds a 1 %/step glide toward each new level.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module duty_level_sequencer
  import duty_seq_pkg::*;
#(
  parameter int unsigned RAMP_STEP_CYC = 100000
) (
  input  logic               sysclk_i,
  input  logic               rst_i,
  input  logic               key_pulse_i,
  output logic [DUTY_W-1:0]  duty_o,
  output logic [LEVEL_W-1:0] level_o,
  output logic               busy_o,
  output logic               duty_upd_o
);

  if (RAMP_STEP_CYC < 2) begin : g_bad_step
    $error("RAMP_STEP_CYC must be at least 2");
  end

  level_t level_q, level_d;
  duty_t  duty_q, duty_d;
  logic   duty_upd_q, duty_upd_d;

`ifdef DUTY_RAMP_EN
  state_e state_q, state_d;
  duty_t  target;
  logic   step_tick;

  ramp_tick #(
    .RAMP_STEP_CYC(RAMP_STEP_CYC)
  ) u_ramp_tick (
    .clk_i (sysclk_i),
    .rst_i (rst_i),
    .en_i  (state_q == RAMP),
    .clr_i (key_pulse_i),
    .tick_o(step_tick)
  );

  always_comb begin
    level_d = level_q;
    duty_d  = duty_q;
    state_d = state_q;
    if (key_pulse_i) begin
      level_d = next_level(level_q);
    end
    target = level_duty(level_d);
    // Tick is never asserted with a key, so target here is the settled one.
    if (step_tick && (duty_q != target)) begin
      duty_d = (duty_q < target) ? duty_q + DUTY_W'(1) : duty_q - DUTY_W'(1);
    end
    state_d = (duty_d != target) ? RAMP : IDLE;
  end

  always_ff @(posedge sysclk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign busy_o = (state_q == RAMP);
`else
  always_comb begin
    level_d = level_q;
    duty_d  = duty_q;
    if (key_pulse_i) begin
      level_d = next_level(level_q);
      duty_d  = level_duty(level_d);
    end
  end

  assign busy_o = 1'b0;
`endif

  assign duty_upd_d = (duty_d != duty_q);

  always_ff @(posedge sysclk_i) begin
    if (rst_i) begin
      level_q    <= '0;
      duty_q     <= '0;
      duty_upd_q <= 1'b0;
    end else begin
      level_q    <= level_d;
      duty_q     <= duty_d;
      duty_upd_q <= duty_upd_d;
    end
  end

  assign duty_o     = duty_q;
  assign level_o    = level_q;
  assign duty_upd_o = duty_upd_q;

endmodule

`default_nettype wire

// File: tb/tb_duty_level_sequencer.sv
// ---------------------------------------------------------------------------
// tb_duty_level_sequencer : directed bench with a cycle-level reference model
//   for duty_level_sequencer (both DUTY_RAMP_EN builds).  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_duty_level_sequencer;

  localparam int STEP = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key = 1'b0;
  logic [6:0] duty;
  logic [2:0] level;
  logic       busy;
  logic       upd;

  int n_checks = 0;
  int n_fail   = 0;
  int upd_cnt  = 0;

  duty_level_sequencer #(
    .RAMP_STEP_CYC(STEP)
  ) dut (
    .sysclk_i   (clk),
    .rst_i      (rst),
    .key_pulse_i(key),
    .duty_o     (duty),
    .level_o    (level),
    .busy_o     (busy),
    .duty_upd_o (upd)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: level/target from the key, duty moves one percent after
  // every STEP cycles spent away from the target since the last key or step.
  int  TBL [6] = '{0, 5, 10, 25, 50, 100};
  int  m_level, m_duty, m_target, m_phase;
  bit  m_upd;
  bit  m_valid = 1'b0;

  always @(posedge clk) begin
    m_upd = 1'b0;
    if (rst) begin
      m_level = 0; m_duty = 0; m_target = 0; m_phase = 0;
      m_valid = 1'b1;
    end else if (key) begin
      m_level  = (m_level == 5) ? 0 : m_level + 1;
      m_target = TBL[m_level];
      m_phase  = 0;
`ifndef DUTY_RAMP_EN
      m_upd  = (m_duty != m_target);
      m_duty = m_target;
`endif
    end else if (m_duty != m_target) begin
      m_phase++;
      if (m_phase == STEP) begin
        m_duty  = (m_target > m_duty) ? m_duty + 1 : m_duty - 1;
        m_phase = 0;
        m_upd   = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_duty",  int'(duty),  m_duty);
      check("model_level", int'(level), m_level);
      check("model_upd",   int'(upd),   int'(m_upd));
`ifdef DUTY_RAMP_EN
      check("model_busy",  int'(busy),  int'(m_duty != m_target));
`else
      check("model_busy",  int'(busy),  0);
`endif
    end
    if (upd === 1'b1) upd_cnt++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Returns at the negedge just after the edge that sampled the key.
  task automatic pulse();
    key = 1'b1;
    @(negedge clk);
    key = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int i;
    for (i = 0; i < limit; i++) begin
      if (busy == 1'b0) break;
      cyc(1);
    end
    check("wait_idle_timeout", int'(i < limit), 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    check("reset_level", int'(level), 0);
    check("reset_duty",  int'(duty),  0);
    check("reset_busy",  int'(busy),  0);
    check("reset_upd",   int'(upd),   0);
  endtask

  initial begin
    int u;
    int i;
    @(negedge clk);
    do_reset();

`ifndef DUTY_RAMP_EN
    begin
      int exp_seq [6] = '{5, 10, 25, 50, 100, 0};
      for (int k = 0; k < 6; k++) begin
        u = upd_cnt;
        pulse();
        check("jump_duty", int'(duty), exp_seq[k]);
        check("jump_upd",  int'(upd),  1);
        check("jump_busy", int'(busy), 0);
        cyc(9);
        check("jump_upd_count", upd_cnt - u, 1);
      end
      check("jump_wrap_level", int'(level), 0);
      key = 1'b1;
      cyc(2);
      key = 1'b0;
      check("held_key_level", int'(level), 2);
      check("held_key_duty",  int'(duty),  10);
      key = 1'b1;
      rst = 1'b1;
      cyc(1);
      key = 1'b0;
      rst = 1'b0;
      check("rst_over_key_level", int'(level), 0);
      check("rst_over_key_duty",  int'(duty),  0);
      cyc(3);
    end
`else
    // Single pulse from reset: 0 -> 5 in five steps of STEP cycles.
    u = upd_cnt;
    pulse();
    check("ramp1_busy",  int'(busy),  1);
    check("ramp1_level", int'(level), 1);
    check("ramp1_duty0", int'(duty),  0);
    for (int k = 1; k <= 5; k++) begin
      cyc(STEP);
      check("ramp1_step", int'(duty), k);
    end
    check("ramp1_busy_end", int'(busy), 0);
    cyc(1);
    check("ramp1_upd_count", upd_cnt - u, 5);

    // Key mid-ramp at DUTY=3 retargets to 10 without restarting.
    do_reset();
    pulse();
    cyc(12);
    check("mid_duty3", int'(duty), 3);
    pulse();
    check("mid_level",     int'(level), 2);
    check("mid_no_drop",   int'(duty),  3);
    check("mid_busy",      int'(busy),  1);
    cyc(3);
    check("mid_hold",      int'(duty),  3);
    cyc(1);
    check("mid_first_step", int'(duty), 4);
    wait_idle(100);
    check("mid_final", int'(duty), 10);

    // Key in the terminal-count cycle suppresses that step.
    pulse();
    cyc(STEP);
    check("tc_first_step", int'(duty), 11);
    cyc(STEP - 1);
    pulse();
    check("tc_level",      int'(level), 4);
    check("tc_suppressed", int'(duty),  11);
    cyc(STEP - 1);
    check("tc_hold",       int'(duty),  11);
    cyc(1);
    check("tc_next_step",  int'(duty),  12);

    // Up to 50, up to 100, wrap to level 0 and ramp down; reset at 37.
    wait_idle(250);
    check("leg50_final", int'(duty), 50);
    pulse();
    wait_idle(250);
    check("leg100_final", int'(duty), 100);
    pulse();
    check("wrap_level", int'(level), 0);
    for (i = 0; i < 400; i++) begin
      if (duty == 7'd37) break;
      cyc(1);
    end
    check("reach37_timeout", int'(i < 400), 1);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check("midrst_duty",  int'(duty),  0);
    check("midrst_level", int'(level), 0);
    check("midrst_busy",  int'(busy),  0);
    check("midrst_upd",   int'(upd),   0);
    u = upd_cnt;
    cyc(8);
    check("midrst_no_upd", upd_cnt - u, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
